if_id_stage: RTL

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/sat_counter.sv | 24 ++
 rtl/if_id_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, IF/ID FSM state encoding, default reset PC.
package pipeline_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; one-cycle update, holds at all-ones.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/if_id_stage.sv
// IF stage PC register plus IF/ID pipeline register with stall/flush FSM and stall watchdog.
// Optional perf counters (StallCount/FlushCount) enabled by IF_ID_STALL_STATS_EN.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          MAX_STALL = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        Flush,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] InstrIn,
    output logic [31:0] PC,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic [1:0]  State,
    output logic        StallError,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic        r_stall_err;
    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] w_pc_plus4;
    logic        w_next_is_stall;
    logic [3:0]  w_stall_run;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc <= RESET_PC;
        end else if (Flush) begin
            r_pc <= BranchTarget;
        end else if (PCWrite) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Flush squashes the ID slot regardless of IF_ID_Write.
    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            r_instr    <= NOP;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (IF_ID_Write) begin
            r_instr    <= InstrIn;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_RUN;
        if (Flush) begin
            w_next_state = ST_FLUSH;
        end else if (!PCWrite || !IF_ID_Write) begin
            w_next_state = ST_STALL;
        end
    end

    assign w_next_is_stall = (w_next_state == ST_STALL);

    sat_counter #(.W(4)) u_stall_run (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_inc   (w_next_is_stall),
        .i_clr   (!w_next_is_stall),
        .o_count (w_stall_run)
    );

    // Fires on the edge that moves the run length from MAX_STALL-1 to MAX_STALL.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_err <= 1'b0;
        end else if (w_next_is_stall && (w_stall_run == 4'(MAX_STALL - 1))) begin
            r_stall_err <= 1'b1;
        end
    end

`ifdef IF_ID_STALL_STATS_EN
    sat_counter #(.W(16)) u_stall_cnt (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_inc   (w_next_is_stall),
        .i_clr   (1'b0),
        .o_count (StallCount)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_inc   (Flush),
        .i_clr   (1'b0),
        .o_count (FlushCount)
    );
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

    assign PC             = r_pc;
    assign Instruction_ID = r_instr;
    assign PCPlus4_ID     = r_pc_plus4;
    assign Valid_ID       = r_valid;
    assign State          = r_state;
    assign StallError     = r_stall_err;

endmodule
